// File: rtl/dmem_bank_sync.sv
// Clocked byte/half/word data memory for the MEM stage, with a valid/ready request
// channel, optional wait states and a one-cycle response pulse.
module dmem_bank_sync #(
  parameter int DEPTH_LOG2  = 7,
  parameter int WAIT_STATES = 0,
  parameter int BIG_ENDIAN  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int         DEPTH    = 2 ** DEPTH_LOG2;
  localparam int         AW       = DEPTH_LOG2 + 2;
  localparam bit         BE       = (BIG_ENDIAN != 0);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  typedef logic [31:0] mem_t [DEPTH];

  function automatic mem_t mem_init();
    for (int i = 0; i < DEPTH; i++) mem_init[i] = 32'(i * 10);
  endfunction

  mem_t mem = mem_init();

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        do_access;
  logic        accept;

  logic          lat_write, lat_signed;
  logic [1:0]    lat_size;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;

  logic          cur_write, cur_signed;
  logic [1:0]    cur_size;
  logic [AW-1:0] cur_addr;
  logic [31:0]   cur_wdata;

  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0] rd_word, shifted, size_mask, load_data, merged;
  logic [4:0]  sh;
  logic        sign_bit, misaligned;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW];

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign accept     = req_valid && req_ready;

  // With no wait states the access happens on the acceptance edge, so the live inputs are used.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_write  = req_write;
      cur_signed = req_signed;
      cur_size   = req_size;
      cur_addr   = req_addr[AW-1:0];
      cur_wdata  = req_wdata;
    end else begin
      cur_write  = lat_write;
      cur_signed = lat_signed;
      cur_size   = lat_size;
      cur_addr   = lat_addr;
      cur_wdata  = lat_wdata;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_access = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            do_access = 1'b1;
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign word_idx = cur_addr[AW-1:2];
  assign rd_word  = mem[word_idx];

  // Lane shift: big-endian puts byte offset 0 in the top byte of the word.
  always_comb begin
    sh         = 5'd0;
    size_mask  = 32'hFFFF_FFFF;
    misaligned = 1'b0;
    case (cur_size)
      2'b00: begin
        sh        = BE ? {~cur_addr[1:0], 3'b000} : {cur_addr[1:0], 3'b000};
        size_mask = 32'h0000_00FF;
      end
      2'b01: begin
        sh         = BE ? {~cur_addr[1], 4'b0000} : {cur_addr[1], 4'b0000};
        size_mask  = 32'h0000_FFFF;
        misaligned = cur_addr[0];
      end
      2'b10:   misaligned = |cur_addr[1:0];
      default: misaligned = 1'b1;
    endcase
    shifted  = rd_word >> sh;
    sign_bit = (cur_size == 2'b00) ? shifted[7] :
               (cur_size == 2'b01) ? shifted[15] : 1'b0;
    load_data = shifted & size_mask;
    if (cur_signed && sign_bit) load_data = load_data | ~size_mask;
    merged = (rd_word & ~(size_mask << sh)) | ((cur_wdata & size_mask) << sh);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_write  <= req_write;
        lat_signed <= req_signed;
        lat_size   <= req_size;
        lat_addr   <= req_addr[AW-1:0];
        lat_wdata  <= req_wdata;
      end
      if (do_access) begin
        resp_error <= misaligned;
        resp_rdata <= (misaligned || cur_write) ? 32'd0 : load_data;
      end
    end
  end

  // NOTE: the memory array has no reset; reset only blocks a pending store from committing.
  always_ff @(posedge clk) begin
    if (!reset && do_access && cur_write && !misaligned) mem[word_idx] <= merged;
  end

endmodule

// File: tb/tb_dmem_bank_sync.sv
// Scoreboard bench for dmem_bank_sync: three instances with 0, 2 and 3 wait states
// share the request fields; a byte-level reference model predicts every response.
module tb_dmem_bank_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             req_write;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [31:0]      req_addr, req_wdata;
  logic [2:0]       req_valid, req_ready, resp_valid, resp_error;
  logic [2:0][31:0] resp_rdata;

  int ws [3] = '{0, 2, 3};

  dmem_bank_sync #(.WAIT_STATES(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]));

  dmem_bank_sync #(.WAIT_STATES(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]));

  dmem_bank_sync #(.WAIT_STATES(3)) u_dut_w3 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[2]),
    .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2]));

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } exp_t;

  exp_t        sb0[$], sb1[$], sb2[$];
  logic [31:0] last_rd [3];
  logic [31:0] model [3][128];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input int d, input exp_t e);
    case (d)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int d, output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '0;
    case (d)
      0:       if (sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
      1:       if (sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
      default: if (sb2.size() > 0) begin e = sb2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Reference model: big-endian byte addressing, byte k of a word lives at bits [31-8k -: 8].
  task automatic model_access(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                              input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int n, wi, off;
    logic [31:0] v;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    wi  = int'(a[8:2]);
    off = int'(a[1:0]);
    e   = '0;
    if (sz == 2'b11 || (off % n) != 0) begin
      e.error = 1'b1;
    end else if (wr) begin
      for (int j = 0; j < n; j++) model[d][wi][31-8*(off+j) -: 8] = wd[8*(n-1-j) +: 8];
    end else begin
      v = 32'd0;
      for (int j = 0; j < n; j++) v = (v << 8) | 32'(model[d][wi][31-8*(off+j) -: 8]);
      if (n < 4 && sg && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      e.rdata = v;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (resp_valid[d]) begin
        bit   ok;
        exp_t e;
        sb_pop(d, ok, e);
        check($sformatf("resp_expected_d%0d", d), 32'(ok), 32'd1);
        if (ok) begin
          check($sformatf("rdata_d%0d", d), resp_rdata[d], e.rdata);
          check($sformatf("error_d%0d", d), 32'(resp_error[d]), 32'(e.error));
          last_rd[d] = e.rdata;
        end
      end
    end
  end

  // Drives a request from a negedge, waits for acceptance and returns at the negedge after it.
  task automatic issue(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit scored,
                       output int stalls);
    exp_t e;
    req_write    = wr;
    req_size     = sz;
    req_signed   = sg;
    req_addr     = a;
    req_wdata    = wd;
    req_valid[d] = 1'b1;
    stalls = 0;
    while (!req_ready[d] && stalls < 40) begin
      @(negedge clk);
      stalls++;
    end
    check($sformatf("accept_d%0d", d), 32'(req_ready[d]), 32'd1);
    if (scored) begin
      model_access(d, wr, sz, sg, a, wd, e);
      sb_push(d, e);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic expect_resp(input int d);
    int k;
    k = 1;
    while (!resp_valid[d] && k < 40) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("latency_d%0d", d), 32'(k), 32'(ws[d] + 1));
    check($sformatf("busy_ready_d%0d", d), 32'(req_ready[d]), 32'd0);
    @(negedge clk);
    check($sformatf("pulse_end_d%0d", d), 32'(resp_valid[d]), 32'd0);
    check($sformatf("ready_back_d%0d", d), 32'(req_ready[d]), 32'd1);
    check($sformatf("hold_d%0d", d), resp_rdata[d], last_rd[d]);
  endtask

  task automatic acc(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                     input logic [31:0] a, input logic [31:0] wd);
    int st;
    issue(d, wr, sz, sg, a, wd, 1'b1, st);
    expect_resp(d);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int st;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 128; i++) model[d][i] = 32'(i * 10);
    reset = 1'b1; req_valid = '0; req_write = 1'b0; req_size = 2'b10;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ready_d%0d", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("rst_valid_d%0d", d), 32'(resp_valid[d]), 32'd0);
      check($sformatf("rst_rdata_d%0d", d), resp_rdata[d], 32'd0);
      check($sformatf("rst_error_d%0d", d), 32'(resp_error[d]), 32'd0);
    end

    // Basic word, byte and half accesses with no wait states
    acc(0, 0, 2'b10, 0, 32'h0C, 0);
    acc(0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF);
    acc(0, 0, 2'b10, 0, 32'h10, 0);
    acc(0, 1, 2'b00, 0, 32'h11, 32'hFFFF_FF80);
    acc(0, 0, 2'b10, 0, 32'h10, 0);
    acc(0, 0, 2'b00, 1, 32'h11, 0);
    acc(0, 0, 2'b00, 0, 32'h11, 0);
    acc(0, 0, 2'b01, 1, 32'h12, 0);
    acc(0, 0, 2'b01, 0, 32'h10, 0);
    acc(0, 0, 2'b01, 1, 32'h10, 0);
    acc(0, 0, 2'b00, 1, 32'h13, 0);
    acc(0, 0, 2'b10, 1, 32'h10, 0);
    // Misaligned and reserved-size accesses, then untouched neighbours
    acc(0, 1, 2'b10, 0, 32'h06, 32'h1234_5678);
    acc(0, 0, 2'b01, 1, 32'h03, 0);
    acc(0, 0, 2'b11, 0, 32'h08, 0);
    acc(0, 0, 2'b10, 0, 32'h04, 0);
    acc(0, 0, 2'b10, 0, 32'h08, 0);
    acc(0, 1, 2'b01, 0, 32'h12, 32'hCAFE_1234);
    acc(0, 0, 2'b10, 0, 32'h10, 0);
    acc(0, 0, 2'b10, 0, 32'h0000_020C, 0);
    acc(0, 0, 2'b10, 0, 32'h1FC, 0);

    // Two wait states: a second request held while busy must wait for IDLE
    issue(1, 0, 2'b10, 0, 32'h0C, 0, 1'b1, st);
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h0C; req_wdata = 32'h0BAD_F00D;
    req_valid[1] = 1'b1;
    expect_resp(1);
    issue(1, 1, 2'b10, 0, 32'h0C, 32'h0BAD_F00D, 1'b1, st);
    check("held_taken_at_idle", 32'(st), 32'd0);
    expect_resp(1);
    acc(1, 0, 2'b10, 0, 32'h0C, 0);
    acc(1, 0, 2'b00, 1, 32'h0E, 0);

    // Three wait states: reset in WAIT drops the store and its response
    acc(2, 0, 2'b10, 0, 32'h20, 0);
    issue(2, 1, 2'b10, 0, 32'h20, 32'hAAAA_5555, 1'b0, st);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("wait_reset_ready", 32'(req_ready[2]), 32'd1);
    check("wait_reset_rdata", resp_rdata[2], 32'd0);
    acc(2, 0, 2'b10, 0, 32'h20, 0);

    // Reset and req_valid together: reset wins
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'h5555_5555;
    reset = 1'b1;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    acc(0, 0, 2'b10, 0, 32'h30, 0);

    // Reset during RESP: the pulse ends and the committed store stays
    issue(0, 1, 2'b10, 0, 32'h34, 32'h1357_9BDF, 1'b1, st);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("resp_reset_valid", 32'(resp_valid[0]), 32'd0);
    check("resp_reset_rdata", resp_rdata[0], 32'd0);
    acc(0, 0, 2'b10, 0, 32'h34, 0);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb0.size() + sb1.size() + sb2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
